// File: rtl/reset_sequencer.sv
// Staged SoC reset release: bus fabric first, then the CPU.
// Soft and watchdog requests re-run the same sequence and set the cause.
module reset_sequencer #(
    parameter int BUS_DLY   = 16,
    parameter int CPU_DLY   = 32,
    parameter int SWRST_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_sw_rst_req,
    input  logic       i_wdt_rst_req,
    output logic       o_bus_rstn,
    output logic       o_cpu_rstn,
    output logic [1:0] o_rst_cause,
    output logic       o_seq_busy
);

    typedef enum logic [1:0] {
        SW_HOLD,
        BUS_WAIT,
        CPU_WAIT,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] BUS_LAST = CNT_W'(BUS_DLY - 1);
    localparam logic [CNT_W-1:0] CPU_LAST = CNT_W'(CPU_DLY - 1);
    localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SWRST_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_q, bus_d;
    logic             cpu_q, cpu_d;
    logic             busy_q, busy_d;
    logic [1:0]       cause_q, cause_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= BUS_WAIT;
            cnt_q   <= '0;
            bus_q   <= 1'b0;
            cpu_q   <= 1'b0;
            busy_q  <= 1'b1;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            cpu_q   <= cpu_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        cpu_d   = cpu_q;
        busy_d  = busy_q;
        cause_d = cause_q;
        unique case (state_q)
            SW_HOLD: begin
                if (cnt_q == SW_LAST) begin
                    cnt_d   = '0;
                    state_d = BUS_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BUS_WAIT: begin
                if (cnt_q == BUS_LAST) begin
                    bus_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = CPU_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CPU_WAIT: begin
                if (cnt_q == CPU_LAST) begin
                    cpu_d   = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                // Watchdog outranks software when both arrive together
                if (i_sw_rst_req || i_wdt_rst_req) begin
                    bus_d   = 1'b0;
                    cpu_d   = 1'b0;
                    busy_d  = 1'b1;
                    cause_d = i_wdt_rst_req ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                    state_d = SW_HOLD;
                end
            end
            default: state_d = BUS_WAIT;
        endcase
    end

    assign o_bus_rstn  = bus_q;
    assign o_cpu_rstn  = cpu_q;
    assign o_seq_busy  = busy_q;
    assign o_rst_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed and random requests against
// a timeline model of sequence start edge and reset cause.
module tb_reset_sequencer;

    localparam int BUS_DLY   = 16;
    localparam int CPU_DLY   = 32;
    localparam int SWRST_LEN = 8;

    logic       clk;
    logic       rstn;
    logic       sw_req;
    logic       wdt_req;
    logic       bus_rstn;
    logic       cpu_rstn;
    logic [1:0] cause;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Model: edges since release, the edge the current sequence started
    // counting from, and the latched cause.
    int         ecnt    = 0;
    int         m_start = 0;
    logic [1:0] m_cause = 2'b00;

    reset_sequencer #(
        .BUS_DLY  (BUS_DLY),
        .CPU_DLY  (CPU_DLY),
        .SWRST_LEN(SWRST_LEN),
        .CNT_W    (8)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_sw_rst_req (sw_req),
        .i_wdt_rst_req(wdt_req),
        .o_bus_rstn   (bus_rstn),
        .o_cpu_rstn   (cpu_rstn),
        .o_rst_cause  (cause),
        .o_seq_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h",
                   tag, ecnt, obs, exp);
        end
    endtask

    function automatic logic exp_bus();
        return (ecnt - m_start) >= BUS_DLY;
    endfunction

    function automatic logic exp_cpu();
        return (ecnt - m_start) >= BUS_DLY + CPU_DLY;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ":bus"}, {1'b0, bus_rstn}, {1'b0, exp_bus()});
        chk({tag, ":cpu"}, {1'b0, cpu_rstn}, {1'b0, exp_cpu()});
        chk({tag, ":busy"}, {1'b0, busy}, {1'b0, !exp_cpu()});
        chk({tag, ":cause"}, cause, m_cause);
        chk({tag, ":inv"}, {1'b0, cpu_rstn & ~bus_rstn}, 2'b00);
    endtask

    task automatic step(input logic sw, input logic wdt, input string tag);
        bit in_run;
        sw_req  = sw;
        wdt_req = wdt;
        in_run  = exp_cpu();
        @(posedge clk);
        ecnt++;
        if (in_run && (sw || wdt)) begin
            m_cause = wdt ? 2'b10 : 2'b01;
            m_start = ecnt + SWRST_LEN;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
    endtask

    task automatic pulse_rstn(input string tag);
        #2;
        rstn = 1'b0;
        #1;
        m_cause = 2'b00;
        m_start = 0;
        ecnt    = 0;
        check_all({tag, ":async"});
        @(posedge clk);
        #1;
        check_all({tag, ":held"});
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        rstn    = 1'b1;
        sw_req  = 1'b0;
        wdt_req = 1'b0;
        #1;
        rstn = 1'b0;
        #1;
        check_all("por_reset");
        @(posedge clk);
        #3;
        rstn = 1'b1;

        // Power-on with an ignored watchdog pulse at edge 20
        idle(15, "por");
        chk("por_bus_e15", {1'b0, bus_rstn}, 2'b00);
        step(1'b0, 1'b0, "por");
        chk("por_bus_e16", {1'b0, bus_rstn}, 2'b01);
        idle(3, "por");
        step(1'b0, 1'b1, "wdt_ignored");
        idle(27, "por");
        chk("por_cpu_e47", {1'b0, cpu_rstn}, 2'b00);
        step(1'b0, 1'b0, "por");
        chk("por_cpu_e48", {1'b0, cpu_rstn}, 2'b01);
        chk("por_cause", cause, 2'b00);
        idle(4, "run");

        // Single software pulse
        step(1'b1, 1'b0, "sw_pulse");
        chk("sw_cause", cause, 2'b01);
        chk("sw_bus_low", {1'b0, bus_rstn}, 2'b00);
        idle(60, "sw_seq");

        // Simultaneous requests: watchdog wins
        step(1'b1, 1'b1, "both");
        chk("both_cause", cause, 2'b10);
        idle(60, "both_seq");

        // Level request held across a sequence retriggers in RUN
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0, "sw_level");
        idle(60, "level_clear");

        // Random request traffic
        for (int i = 0; i < 600; i++) begin
            logic r_sw;
            logic r_wdt;
            r_sw  = ($urandom_range(0, 15) == 0);
            r_wdt = ($urandom_range(0, 23) == 0);
            step(r_sw, r_wdt, "rand");
        end
        idle(60, "rand_drain");

        // i_rstn pulse mid-sequence at edge 30
        pulse_rstn("rst_start");
        idle(30, "pre_mid");
        pulse_rstn("rst_mid");
        idle(60, "restart");

        // Watchdog reset, then power-on clears the cause
        step(1'b0, 1'b1, "wdt");
        chk("wdt_cause", cause, 2'b10);
        idle(30, "wdt_seq");
        pulse_rstn("wdt_then_por");
        chk("por_clears_cause", cause, 2'b00);
        idle(50, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
